// File: rtl/post_process_sched.sv
// Round-robin scheduler, bias-read sequencer and result FIFO for the post-process array.
// Define PP_SCHED_PERF_EN to add the perf_tiles/perf_stall saturating counters.
module post_process_sched #(
  parameter int NREQ       = 2,
  parameter int LANES      = 32,
  parameter int GRP_W      = 6,
  parameter int FIFO_DEPTH = 8,
  localparam int SRC_W     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*LANES*32-1:0] req_acc_flat,
  input  logic [NREQ*GRP_W-1:0]    req_grp,
  output logic                     bias_rd_en,
  output logic [GRP_W-1:0]         bias_rd_addr,
  output logic                     pp_valid,
  output logic [LANES*32-1:0]      pp_acc_flat,
  input  logic [LANES*8-1:0]       pp_result_flat,
  input  logic                     pp_done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*8-1:0]       out_data,
  output logic [GRP_W-1:0]         out_grp,
  output logic [SRC_W-1:0]         out_src,
  output logic                     busy,
  output logic                     err_sync
`ifdef PP_SCHED_PERF_EN
  ,
  output logic [31:0]              perf_tiles,
  output logic [31:0]              perf_stall
`endif
);

  localparam int ACC_W = LANES * 32;
  localparam int RES_W = LANES * 8;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  logic [SRC_W-1:0] last_grant;
  logic [SRC_W-1:0] sel;
  logic             found;
  logic             credit_ok;
  logic             xfer;
  int               idx;

  logic [5:1]       sv;
  logic [ACC_W-1:0] s1_acc;
  logic [ACC_W-1:0] s2_acc;
  logic [GRP_W-1:0] sg [1:5];
  logic [SRC_W-1:0] ss [1:5];
  logic [2:0]       inflight;
  logic             s5_d;

  logic [RES_W-1:0] f_data [FIFO_DEPTH];
  logic [GRP_W-1:0] f_grp  [FIFO_DEPTH];
  logic [SRC_W-1:0] f_src  [FIFO_DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  always_comb begin
    found = 1'b0;
    sel   = last_grant;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(last_grant) + 1 + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = SRC_W'(idx);
      end
    end
  end

  // Tiles in S1..S5 already own a FIFO slot; a pop this cycle is not credited.
  assign inflight  = 3'($countones(sv));
  assign credit_ok = ({1'b0, count} + (CNT_W+1)'(inflight))
                     < (CNT_W+1)'(FIFO_DEPTH);
  assign xfer      = found & credit_ok & ~rst;
  assign req_ready = xfer ? (NREQ'(1) << sel) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant <= SRC_W'(NREQ - 1);
    else if (xfer) last_grant <= sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sv     <= '0;
      s1_acc <= '0;
      s2_acc <= '0;
      for (int k = 1; k <= 5; k++) begin
        sg[k] <= '0;
        ss[k] <= '0;
      end
    end else begin
      sv <= {sv[4:1], xfer};
      if (xfer) begin
        s1_acc <= req_acc_flat[int'(sel)*ACC_W +: ACC_W];
        sg[1]  <= req_grp[int'(sel)*GRP_W +: GRP_W];
        ss[1]  <= sel;
      end
      if (sv[1]) s2_acc <= s1_acc;
      for (int k = 2; k <= 5; k++) begin
        if (sv[k-1]) begin
          sg[k] <= sg[k-1];
          ss[k] <= ss[k-1];
        end
      end
    end
  end

  assign bias_rd_en   = sv[1];
  assign bias_rd_addr = sg[1];
  assign pp_valid     = sv[2];
  assign pp_acc_flat  = s2_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s5_d     <= 1'b0;
      err_sync <= 1'b0;
    end else begin
      s5_d     <= sv[5];
      err_sync <= err_sync | (pp_done != s5_d);
    end
  end

  assign push      = sv[5];
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      f_data[wp] <= pp_result_flat;
      f_grp[wp]  <= sg[5];
      f_src[wp]  <= ss[5];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  assign out_data = out_valid ? f_data[rp] : '0;
  assign out_grp  = out_valid ? f_grp[rp]  : '0;
  assign out_src  = out_valid ? f_src[rp]  : '0;
  assign busy     = (|sv) | out_valid;

`ifdef PP_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_tiles <= '0;
      perf_stall <= '0;
    end else begin
      if (push && perf_tiles != '1) perf_tiles <= perf_tiles + 1'b1;
      if ((|req_valid) && !xfer && perf_stall != '1)
        perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_post_process_sched.sv
// Directed scoreboard bench for post_process_sched with a
// bias-memory and post-process array model.
module tb_post_process_sched;

  localparam int NREQ = 2;
  localparam int LANES = 32;
  localparam int GRP_W = 6;
  localparam int ACC_W = LANES * 32;
  localparam int RES_W = LANES * 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*ACC_W-1:0]   req_acc_flat;
  logic [NREQ*GRP_W-1:0]   req_grp;
  logic                    bias_rd_en;
  logic [GRP_W-1:0]        bias_rd_addr;
  logic                    pp_valid;
  logic [ACC_W-1:0]        pp_acc_flat;
  logic [RES_W-1:0]        pp_result_flat;
  logic                    pp_done;
  logic                    out_valid;
  logic                    out_ready;
  logic [RES_W-1:0]        out_data;
  logic [GRP_W-1:0]        out_grp;
  logic [0:0]              out_src;
  logic                    busy;
  logic                    err_sync;

  post_process_sched dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_acc_flat(req_acc_flat), .req_grp(req_grp),
    .bias_rd_en(bias_rd_en), .bias_rd_addr(bias_rd_addr),
    .pp_valid(pp_valid), .pp_acc_flat(pp_acc_flat),
    .pp_result_flat(pp_result_flat), .pp_done(pp_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_grp(out_grp), .out_src(out_src),
    .busy(busy), .err_sync(err_sync)
  );

  always #5 clk = ~clk;

  function automatic int bias_of(input logic [GRP_W-1:0] g);
    return (g == 6'd5) ? 0 : int'(g) * 9 - 100;
  endfunction

  // bias + LeakyReLU (slope 1/8) + unity requantize, saturated to int8
  function automatic logic [RES_W-1:0] arr(input logic [ACC_W-1:0] a,
                                           input int b);
    logic [RES_W-1:0] r;
    int s;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      s = $signed(a[l*32 +: 32]) + b;
      if (s < 0) s = s >>> 3;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      r[l*8 +: 8] = s[7:0];
    end
    return r;
  endfunction

  function automatic logic [ACC_W-1:0] mk_acc(input int v);
    logic [ACC_W-1:0] a;
    for (int l = 0; l < LANES; l++) a[l*32 +: 32] = v - l * 40;
    return a;
  endfunction

  logic [31:0]      bias_q;
  logic [RES_W-1:0] r1, r2, r3;
  logic             v1, v2, v3, v4;
  logic             inject;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bias_q <= '0;
      r1 <= '0; r2 <= '0; r3 <= '0;
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; v4 <= 1'b0;
    end else begin
      if (bias_rd_en) bias_q <= bias_of(bias_rd_addr);
      if (pp_valid) r1 <= arr(pp_acc_flat, $signed(bias_q));
      r2 <= r1; r3 <= r2;
      v1 <= pp_valid; v2 <= v1; v3 <= v2; v4 <= v3;
    end
  end

  assign pp_result_flat = r3;
  assign pp_done        = v4 | inject;

  typedef struct {
    logic [RES_W-1:0] d;
    logic [GRP_W-1:0] g;
    logic [0:0]       s;
  } exp_t;

  exp_t exp_q[$];
  int   gseq[$];
  int   checks = 0;
  int   errors = 0;
  int   nxfer = 0;
  int   npop = 0;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input int i, input int v, input int g);
    req_acc_flat[i*ACC_W +: ACC_W] = mk_acc(v);
    req_grp[i*GRP_W +: GRP_W] = GRP_W'(g);
  endtask

  // Account for this cycle's handshakes, then advance to the next negedge.
  task automatic tick();
    exp_t e;
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.d = arr(req_acc_flat[i*ACC_W +: ACC_W],
                  bias_of(req_grp[i*GRP_W +: GRP_W]));
        e.g = req_grp[i*GRP_W +: GRP_W];
        e.s = 1'(i);
        exp_q.push_back(e);
        gseq.push_back(i);
        nxfer++;
      end
    end
    if (out_valid && out_ready) begin
      npop++;
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_grp", out_grp, e.g);
        chk("out_src", out_src, e.s);
      end
    end
    @(negedge clk);
  endtask

  task automatic chk_reset();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_bias_en", bias_rd_en, 0);
    chk("rst_bias_addr", bias_rd_addr, 0);
    chk("rst_pp_valid", pp_valid, 0);
    chk("rst_pp_acc", pp_acc_flat, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_grp", out_grp, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_sync", err_sync, 0);
  endtask

  logic [19:0] ov;

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_acc_flat = '0;
    req_grp = '0;
    out_ready = 1'b0;
    inject = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_reset();
    rst = 1'b0;
    @(negedge clk);

    // single tile, req 0, grp 5
    out_ready = 1'b1;
    req_valid = 2'b01;
    drive(0, 1000, 5);
    #1;
    chk("t1_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    chk("t1_bias_en_c1", bias_rd_en, 1);
    chk("t1_bias_addr_c1", bias_rd_addr, 5);
    chk("t1_pp_valid_c1", pp_valid, 0);
    tick();
    chk("t1_pp_valid_c2", pp_valid, 1);
    chk("t1_pp_acc_c2", pp_acc_flat, mk_acc(1000));
    chk("t1_bias_en_c2", bias_rd_en, 0);
    chk("t1_bias_hold_c2", bias_rd_addr, 5);
    tick();
    chk("t1_busy_c3", busy, 1);
    tick();
    tick();
    chk("t1_out_valid_c5", out_valid, 0);
    tick();
    chk("t1_out_valid_c6", out_valid, 1);
    chk("t1_lane0", out_data[7:0], 8'd127);
    chk("t1_grp", out_grp, 5);
    chk("t1_src", out_src, 0);
    tick();
    tick();
    chk("t1_busy_idle", busy, 0);
    chk("t1_err", err_sync, 0);

    // both requesters streaming from a fresh arbiter state
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    gseq.delete();
    ov = '0;
    for (int c = 0; c < 20; c++) begin
      if (c < 8) begin
        req_valid = 2'b11;
        drive(0, 100 * c + 3, 2 * c);
        drive(1, -50 * c + 77, 2 * c + 1);
        #1;
        chk("t2_grant", req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      end else begin
        req_valid = '0;
      end
      ov[c] = out_valid;
      tick();
    end
    chk("t2_ov_pattern", ov, 20'h03FC0);
    chk("t2_ngrant", gseq.size(), 8);
    for (int k = 0; k < gseq.size() && k < 8; k++)
      chk("t2_grant_order", gseq[k], k % 2);
    chk("t2_err", err_sync, 0);
    chk("t2_drained", exp_q.size(), 0);

    // backpressure: credits stop req 0 after 8 tiles
    out_ready = 1'b0;
    nxfer = 0;
    req_valid = 2'b01;
    for (int c = 0; c < 20; c++) begin
      drive(0, 2000 + 3 * c, c);
      tick();
    end
    #1;
    chk("t3_nxfer", nxfer, 8);
    chk("t3_ready_full", req_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_ready_after_pop", req_ready, 2'b01);
    tick();
    req_valid = '0;
    chk("t3_nxfer_after", nxfer, 9);
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    chk("t3_drained", exp_q.size(), 0);

    // push and pop in the same cycle with three entries buffered
    out_ready = 1'b0;
    req_valid = 2'b01;
    for (int c = 0; c < 3; c++) begin
      drive(0, -300 + 211 * c, 40 + c);
      tick();
    end
    req_valid = '0;
    for (int c = 0; c < 8; c++) tick();
    req_valid = 2'b01;
    drive(0, 555, 50);
    tick();
    req_valid = '0;
    for (int c = 1; c < 5; c++) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    npop = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    chk("t4_count_after", npop, 3);
    chk("t4_drained", exp_q.size(), 0);

    // spurious pp_done with the pipeline empty
    out_ready = 1'b0;
    chk("t5_err_before", err_sync, 0);
    inject = 1'b1;
    tick();
    inject = 1'b0;
    chk("t5_err_rise", err_sync, 1);
    for (int c = 0; c < 3; c++) tick();
    chk("t5_err_sticky", err_sync, 1);

    // reset with 2 buffered and 4 in flight
    req_valid = 2'b01;
    for (int c = 0; c < 2; c++) begin
      drive(0, 60 + c, 20 + c);
      tick();
    end
    req_valid = '0;
    for (int c = 0; c < 6; c++) tick();
    req_valid = 2'b01;
    for (int c = 0; c < 4; c++) begin
      drive(0, 900 - 70 * c, 30 + c);
      tick();
    end
    req_valid = '0;
    chk("t6_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk_reset();
    exp_q.delete();
    gseq.delete();
    tick();
    rst = 1'b0;
    tick();
    req_valid = 2'b01;
    drive(0, 777, 9);
    tick();
    req_valid = '0;
    for (int c = 1; c < 5; c++) tick();
    chk("t6_out_valid_c5", out_valid, 0);
    tick();
    chk("t6_out_valid_c6", out_valid, 1);
    chk("t6_grp", out_grp, 9);
    out_ready = 1'b1;
    tick();
    tick();
    chk("t6_err", err_sync, 0);
    chk("t6_busy_idle", busy, 0);
    chk("t6_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
